shift_serializer_hs: RTL and testbench

- Parametrised successor to the fixed-ratio shift serializer.
- Converts a FROM_W-bit parallel word into RATIO = FROM_W/TO_W consecutive TO_W-bit beats.
- Valid/ready handshakes on both sides, a one-word holding buffer for bubble-free back-to-back words, and a per-word selectable slice order (MSB-slice first or LSB-slice first).
- Sits between wide datapath producers and narrow link/IO lanes in the mixed serializer path.

---
 rtl/serializer_pkg.sv | 20 ++
 rtl/ser_hold_buf.sv | 40 ++++
 rtl/shift_serializer_hs.sv | 132 +++++++++++++
 tb/tb_shift_serializer_hs.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared types and sizing helpers for the shift serializer family.
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  function automatic int ratio_f(input int from_w, input int to_w);
    return from_w / to_w;
  endfunction

  // A single-beat word still needs a one-bit counter to keep ports legal.
  function automatic int cnt_w_f(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  localparam int MIN_CNT_W = 1;

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry valid/ready holding register; when empty the upstream word is
// presented downstream combinationally (bypass).
module ser_hold_buf
  import serializer_pkg::*;
#(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] up_data,
  input  logic         up_valid,
  output logic         up_ready,
  output logic [W-1:0] dn_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic         full
);

  logic [W-1:0] mem_q;
  logic         full_q;

  assign up_ready = !full_q;
  assign dn_valid = full_q | up_valid;
  assign dn_data  = full_q ? mem_q : up_data;
  assign full     = full_q;

  // While full, upstream is stalled, so a drain never coincides with a fill.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= 1'b0;
      mem_q  <= '0;
    end else if (full_q) begin
      if (dn_ready) full_q <= 1'b0;
    end else if (up_valid && !dn_ready) begin
      full_q <= 1'b1;
      mem_q  <= up_data;
    end
  end

endmodule

// File: rtl/shift_serializer_hs.sv
// Wide-to-narrow serializer with valid/ready on both sides, a one-word holding
// buffer and per-word slice order. Optional parity_o via SHIFT_SERIALIZER_PARITY_EN.
//
// state | meaning
// IDLE  | no word in flight, accepting directly into the shift register
// SHIFT | presenting beats of the current word
module shift_serializer_hs
  import serializer_pkg::*;
#(
  parameter int FROM_W = 64,
  parameter int TO_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [FROM_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              msb_first_i,
  output logic [TO_W-1:0]   data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o,
  output logic              busy_o
`ifdef SHIFT_SERIALIZER_PARITY_EN
  ,
  output logic              parity_o
`endif
);

  localparam int RATIO = ratio_f(FROM_W, TO_W);
  localparam int CNT_W = cnt_w_f(RATIO);

  ser_state_e        state_q, state_d;
  logic [FROM_W-1:0] sr_q, sr_d;
  logic              ord_q, ord_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              arm_q;
  logic [FROM_W:0]   hb_data;
  logic              hb_valid, hb_ready, hb_take, hb_full;
  logic              xfer, at_last;
  logic [TO_W-1:0]   slice;

  ser_hold_buf #(.W(FROM_W + 1)) u_hold (
    .clk      (clk),
    .reset_n  (reset_n),
    .up_data  ({msb_first_i, data_i}),
    .up_valid (valid_i & arm_q),
    .up_ready (hb_ready),
    .dn_data  (hb_data),
    .dn_valid (hb_valid),
    .dn_ready (hb_take),
    .full     (hb_full)
  );

  assign valid_o = (state_q == SHIFT);
  assign at_last = (cnt_q == CNT_W'(RATIO - 1));
  assign xfer    = valid_o & ready_i;
  assign last_o  = valid_o & at_last;
  // arm_q holds ready_o low until the first edge after reset release.
  assign ready_o = arm_q & hb_ready;
  assign busy_o  = valid_o | hb_full;
  assign slice   = ord_q ? sr_q[FROM_W-1 -: TO_W] : sr_q[TO_W-1:0];
  assign data_o  = valid_o ? slice : '0;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    ord_d   = ord_q;
    cnt_d   = cnt_q;
    hb_take = 1'b0;
    case (state_q)
      IDLE: begin
        hb_take = 1'b1;
        if (hb_valid) begin
          sr_d    = hb_data[FROM_W-1:0];
          ord_d   = hb_data[FROM_W];
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (xfer) begin
          if (at_last) begin
            hb_take = 1'b1;
            if (hb_valid) begin
              sr_d  = hb_data[FROM_W-1:0];
              ord_d = hb_data[FROM_W];
              cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            sr_d  = ord_q ? (sr_q << TO_W) : (sr_q >> TO_W);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      ord_q   <= 1'b0;
      cnt_q   <= '0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      ord_q   <= ord_d;
      cnt_q   <= cnt_d;
      arm_q   <= 1'b1;
    end
  end

`ifdef SHIFT_SERIALIZER_PARITY_EN
  logic [TO_W-1:0] slice_d;
  logic            par_q;

  assign slice_d = ord_d ? sr_d[FROM_W-1 -: TO_W] : sr_d[TO_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) par_q <= 1'b0;
    else          par_q <= (state_d == SHIFT) ? ^slice_d : 1'b0;
  end

  assign parity_o = par_q;
`endif

endmodule

// File: tb/tb_shift_serializer_hs.sv
// Directed bench for shift_serializer_hs at FROM_W=16, TO_W=4.
module tb_shift_serializer_hs;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic        msb_first_i;
  logic [3:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic        last_o;
  logic        busy_o;
`ifdef SHIFT_SERIALIZER_PARITY_EN
  logic        parity_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  shift_serializer_hs #(.FROM_W(16), .TO_W(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .msb_first_i (msb_first_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .last_o      (last_o),
    .busy_o      (busy_o)
`ifdef SHIFT_SERIALIZER_PARITY_EN
    ,
    .parity_o    (parity_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [3:0] d, input logic l);
    chk({tag, "_valid"}, 32'(valid_o), 32'd1);
    chk({tag, "_data"},  32'(data_o),  32'(d));
    chk({tag, "_last"},  32'(last_o),  32'(l));
    tick();
  endtask

  task automatic send(input logic [15:0] w, input logic msb);
    data_i      = w;
    msb_first_i = msb;
    valid_i     = 1'b1;
    chk("send_ready", 32'(ready_o), 32'd1);
    tick();
    valid_i     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] bp_exp [4];
    logic       bp_rdy [8];
    int         bi;

    reset_n = 1'b0; data_i = '0; valid_i = 1'b0; msb_first_i = 1'b0; ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_last",  32'(last_o),  32'd0);
    chk("rst_data",  32'(data_o),  32'd0);
    chk("rst_busy",  32'(busy_o),  32'd0);
    reset_n = 1'b1;
    #1;
    chk("rel_ready_pre_edge", 32'(ready_o), 32'd0);
    tick();
    chk("rel_ready_post_edge", 32'(ready_o), 32'd1);

    // MSB first: A,B,C,D
    send(16'hABCD, 1'b1);
    beat("m0", 4'hA, 1'b0);
    beat("m1", 4'hB, 1'b0);
    beat("m2", 4'hC, 1'b0);
    beat("m3", 4'hD, 1'b1);
    chk("m_idle_valid", 32'(valid_o), 32'd0);
    chk("m_idle_busy",  32'(busy_o),  32'd0);

    // LSB first: D,C,B,A
    send(16'hABCD, 1'b0);
    beat("l0", 4'hD, 1'b0);
    beat("l1", 4'hC, 1'b0);
    beat("l2", 4'hB, 1'b0);
    beat("l3", 4'hA, 1'b1);
    chk("l_idle_valid", 32'(valid_o), 32'd0);

    // Back-to-back through the buffer, then a bypass load on the last beat
    send(16'h1234, 1'b1);
    data_i = 16'h5678; msb_first_i = 1'b0; valid_i = 1'b1;
    chk("bb_ready_empty", 32'(ready_o), 32'd1);
    beat("bb0", 4'h1, 1'b0);
    valid_i = 1'b0;
    chk("bb_ready_full", 32'(ready_o), 32'd0);
    chk("bb_busy", 32'(busy_o), 32'd1);
    beat("bb1", 4'h2, 1'b0);
    chk("bb_ready_full2", 32'(ready_o), 32'd0);
    beat("bb2", 4'h3, 1'b0);
    beat("bb3", 4'h4, 1'b1);
    chk("bb_ready_drained", 32'(ready_o), 32'd1);
    beat("bb4", 4'h8, 1'b0);
    beat("bb5", 4'h7, 1'b0);
    beat("bb6", 4'h6, 1'b0);
    data_i = 16'h9ABC; msb_first_i = 1'b1; valid_i = 1'b1;
    chk("bp_ready_last", 32'(ready_o), 32'd1);
    beat("bb7", 4'h5, 1'b1);
    valid_i = 1'b0;
    chk("byp_buf_empty_ready", 32'(ready_o), 32'd1);
    beat("byp0", 4'h9, 1'b0);
    beat("byp1", 4'hA, 1'b0);
    beat("byp2", 4'hB, 1'b0);
    beat("byp3", 4'hC, 1'b1);
    chk("byp_idle", 32'(valid_o), 32'd0);

    // Backpressure: ready_i = 1,0,0,1,0,1,0,1 -> transfers at steps 0,3,5,7
    bp_exp = '{4'hA, 4'hB, 4'hC, 4'hD};
    bp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    send(16'hABCD, 1'b1);
    bi = 0;
    for (int k = 0; k < 8; k++) begin
      ready_i = bp_rdy[k];
      #1;
      chk("bkp_valid", 32'(valid_o), 32'd1);
      chk("bkp_data",  32'(data_o),  32'(bp_exp[bi]));
      chk("bkp_last",  32'(last_o),  32'(bi == 3));
      tick();
      if (bp_rdy[k]) bi++;
    end
    ready_i = 1'b1;
    chk("bkp_count", 32'(bi), 32'd4);
    chk("bkp_idle", 32'(valid_o), 32'd0);

    // Reset mid-word with a second word buffered
    send(16'hABCD, 1'b1);
    data_i = 16'h1111; msb_first_i = 1'b1; valid_i = 1'b1;
    beat("rm0", 4'hA, 1'b0);
    valid_i = 1'b0;
    chk("rm_data_b", 32'(data_o), 32'hB);
    chk("rm_ready_full", 32'(ready_o), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rm_valid0", 32'(valid_o), 32'd0);
    chk("rm_data0",  32'(data_o),  32'd0);
    chk("rm_ready0", 32'(ready_o), 32'd0);
    chk("rm_busy0",  32'(busy_o),  32'd0);
    chk("rm_last0",  32'(last_o),  32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("rm_ready_back", 32'(ready_o), 32'd1);
    chk("rm_no_beat1", 32'(valid_o), 32'd0);
    chk("rm_not_busy", 32'(busy_o), 32'd0);
    tick();
    chk("rm_no_beat2", 32'(valid_o), 32'd0);
    send(16'h00F0, 1'b1);
    beat("f0", 4'h0, 1'b0);
    beat("f1", 4'h0, 1'b0);
    beat("f2", 4'hF, 1'b0);
    beat("f3", 4'h0, 1'b1);
    chk("f_idle", 32'(valid_o), 32'd0);

`ifdef SHIFT_SERIALIZER_PARITY_EN
    chk("par_idle", 32'(parity_o), 32'd0);
    send(16'h7E10, 1'b1);
    chk("par0", 32'(parity_o), 32'd1);
    beat("p0", 4'h7, 1'b0);
    chk("par1", 32'(parity_o), 32'd1);
    beat("p1", 4'hE, 1'b0);
    chk("par2", 32'(parity_o), 32'd1);
    beat("p2", 4'h1, 1'b0);
    chk("par3", 32'(parity_o), 32'd0);
    beat("p3", 4'h0, 1'b1);
    chk("par_after", 32'(parity_o), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
